// File: rtl/instr_loader.sv
// instr_loader
//
// Writer side of the instruction memory write port. A host byte stream
// (valid/ready) carries a little-endian 32-bit word count N followed by N
// little-endian instruction words. Each assembled word is written to
// instruction memory in a single one-cycle WRITE state. When all N words
// are written the loader raises done so the core can be released. A header
// that asks for more words than the memory holds raises err instead, and
// nothing is written.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start           one-cycle pulse that begins a load session (ignored while busy)
//   rx_valid        byte available on rx_data
//   rx_data         stream byte
//   rx_ready        loader accepts a byte this cycle (HDR and DATA only)
//   mem_we, mem_en  instruction memory write strobe (WRITE state only)
//   mem_addr        byte address of the word being written
//   mem_din         word being written
//   busy            session in progress (HDR, DATA, WRITE)
//   done            load completed; held until the next start or reset
//   err             header word count too large; held until the next start or reset
//   words_loaded    number of words written this session

module instr_loader #(
    parameter int          DEPTH_WORDS = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    logic [2:0]  state;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;
    logic [15:0] word_target;
    logic [15:0] words_cnt;
    logic        xfer;
    logic [31:0] full_word;
    logic [15:0] next_cnt;

    // The assembly register keeps only the three earlier bytes; the fourth
    // byte is still on rx_data when the word completes, so the complete
    // word is formed combinationally at that moment.
    assign xfer      = rx_valid & rx_ready;
    assign full_word = {rx_data, asm_word};
    assign next_cnt  = words_cnt + 16'd1;

    // Main FSM. The word index and words_loaded always hold the same value,
    // so a single counter serves both roles. The write address and data are
    // registered on the last byte of each word and then simply hold, which
    // keeps them stable outside WRITE. byte_cnt is two bits wide and wraps
    // back to zero by itself on every fourth byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            asm_word    <= 24'd0;
            word_target <= 16'd0;
            words_cnt   <= 16'd0;
            mem_addr    <= BASE_ADDR;
            mem_din     <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= HDR;
                        byte_cnt  <= 2'd0;
                        words_cnt <= 16'd0;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_word <= {rx_data, asm_word[23:8]};
                        if (byte_cnt == 2'd3) begin
                            word_target <= full_word[15:0];
                            if (full_word == 32'd0) begin
                                state <= DONE;
                            end else if (full_word > DEPTH_LIMIT) begin
                                state <= ERR;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_word <= {rx_data, asm_word[23:8]};
                        if (byte_cnt == 2'd3) begin
                            mem_din  <= full_word;
                            mem_addr <= BASE_ADDR + {14'd0, words_cnt, 2'b00};
                            state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    words_cnt <= next_cnt;
                    state     <= (next_cnt == word_target) ? DONE : DATA;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status and handshake outputs decode straight from the state, so an
    // asynchronous reset takes them to their idle values at once.
    always_comb begin
        rx_ready     = (state == HDR) || (state == DATA);
        mem_we       = (state == WRITE);
        mem_en       = (state == WRITE);
        busy         = (state == HDR) || (state == DATA) || (state == WRITE);
        done         = (state == DONE);
        err          = (state == ERR);
        words_loaded = words_cnt;
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader
//
// Self-checking bench for instr_loader. A driver streams a header and
// payload words (optionally with random valid gaps). A monitor logs every
// memory write with the cycle in which it was seen. After each session the
// log is compared against a reference built from the loader's rules:
// word k lands at BASE+4k with the k-th payload word, one cycle after its
// last byte is accepted. Headers of 0 or above 32 produce no writes.

module tb_instr_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [31:0] words [0:63];

    logic [31:0] wrAddr  [$];
    logic [31:0] wrDin   [$];
    int          wrCycle [$];
    int          hsCycle [$];
    int          readyDuringWrite = 0;
    int          enMismatch = 0;

    instr_loader #(.DEPTH_WORDS(32), .BASE_ADDR(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Write monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wrAddr.push_back(mem_addr);
            wrDin.push_back(mem_din);
            wrCycle.push_back(cycle);
            if (rx_ready) readyDuringWrite++;
        end
        if (mem_we !== mem_en) enMismatch++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic clearLogs();
        wrAddr.delete();
        wrDin.delete();
        wrCycle.delete();
        hsCycle.delete();
        readyDuringWrite = 0;
        enMismatch = 0;
    endtask

    // Offer one byte, optionally after a random idle gap, and wait a bounded
    // time for the handshake. hs returns the cycle count seen just before
    // the accepting edge, or -1 on timeout.
    task automatic sendByte(input logic [7:0] b, input bit gaps, output int hs);
        int g;
        int waitCnt;
        hs = -1;
        if (gaps) begin
            g = $urandom_range(0, 3);
            repeat (g) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        waitCnt  = 0;
        while (!rx_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (rx_ready) begin
            hs = cycle;
            @(posedge clk);
        end else begin
            checkOutput("byte_accept_timeout", 32'd0, 32'd1);
        end
    endtask

    // Start pulse, header N, then the payload words (only when the loader
    // should take them). byteLimit < 0 sends all payload bytes.
    task automatic applyStimulus(input int n, input bit gaps, input int byteLimit);
        int hs;
        int total;
        logic [31:0] w;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = n;
        for (int i = 0; i < 4; i++) begin
            sendByte(w[8*i +: 8], gaps, hs);
            if (hs < 0) return;
        end
        if (n >= 1 && n <= 32) begin
            total = (byteLimit < 0) ? 4 * n : byteLimit;
            for (int j = 0; j < total; j++) begin
                w = words[j / 4];
                sendByte(w[8*(j % 4) +: 8], gaps, hs);
                if (hs < 0) return;
                if (j % 4 == 3) hsCycle.push_back(hs);
            end
        end
    endtask

    // Run one complete session and compare against the reference.
    task automatic runSession(input string name, input int n, input bit gaps);
        int waitCnt;
        int expWrites;
        int expWait;
        bit ok;
        clearLogs();
        applyStimulus(n, gaps, -1);
        ok = (n >= 1 && n <= 32);
        expWrites = ok ? n : 0;
        expWait   = ok ? 1 : 0;
        @(negedge clk);
        rx_valid = 1'b0;
        waitCnt = 0;
        while (!(done || err) && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput({name, "_finish_latency"}, waitCnt, expWait);
        checkOutput({name, "_write_count"}, wrAddr.size(), expWrites);
        for (int k = 0; k < expWrites && k < wrAddr.size(); k++) begin
            checkOutput($sformatf("%s_addr%0d", name, k), wrAddr[k], 32'(4 * k));
            checkOutput($sformatf("%s_din%0d", name, k), wrDin[k], words[k]);
            if (k < hsCycle.size())
                checkOutput($sformatf("%s_lat%0d", name, k), wrCycle[k], hsCycle[k] + 1);
        end
        checkOutput({name, "_done"}, done, ok || n == 0);
        checkOutput({name, "_err"}, err, n > 32);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_rx_ready"}, rx_ready, 0);
        checkOutput({name, "_words_loaded"}, words_loaded, 32'(expWrites));
        checkOutput({name, "_ready_in_write"}, readyDuringWrite, 0);
        checkOutput({name, "_en_tracks_we"}, enMismatch, 0);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_rx_ready"}, rx_ready, 0);
        checkOutput({name, "_mem_we"}, mem_we, 0);
        checkOutput({name, "_mem_en"}, mem_en, 0);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_done"}, done, 0);
        checkOutput({name, "_err"}, err, 0);
        checkOutput({name, "_mem_addr"}, mem_addr, 32'h0);
        checkOutput({name, "_mem_din"}, mem_din, 32'h0);
        checkOutput({name, "_words_loaded"}, words_loaded, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;

        // Single word from the example stream.
        words[0] = 32'h00100513;
        runSession("single", 1, 1'b0);

        // Full memory with a recognisable pattern.
        for (int k = 0; k < 32; k++) words[k] = k * 32'h01010101;
        runSession("full", 32, 1'b0);

        // Oversized header, then recovery with a one-word load.
        runSession("too_big", 33, 1'b0);
        words[0] = $urandom;
        runSession("recover", 1, 1'b0);

        // Empty load.
        runSession("empty", 0, 1'b0);

        // Same four random words with and without valid gaps.
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        runSession("nogap", 4, 1'b0);
        runSession("gaps", 4, 1'b1);

        // Random sizes with gaps.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 32; k++) words[k] = $urandom;
            runSession($sformatf("rand%0d", r), $urandom_range(1, 32), 1'b1);
        end

        // Reset in the middle of word 3 (index 3) of a four-word load.
        for (int k = 0; k < 4; k++) words[k] = $urandom;
        clearLogs();
        applyStimulus(4, 1'b0, 14);
        @(negedge clk);
        rx_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("midreset");
        checkOutput("midreset_writes_before", wrAddr.size(), 3);
        @(negedge clk);
        rst = 1'b0;

        words[0] = $urandom;
        words[1] = $urandom;
        runSession("restart", 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so the run cannot hang.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
